// File: rtl/multicycle_control_unit_if.sv
// Instruction/data memory request-acknowledge bundle for the multi-cycle control unit.
// The control unit drives the requests through the master modport.
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input  imem_ack, input  dmem_ack);
  modport slave  (input  imem_req, input  dmem_req, input  dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory handshakes and bus timeout.
// Optional M-extension decode and multi-cycle EXEC are enabled by defining MULDIV_EN.
module multicycle_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  op,
  input  logic [2:0]  func3,
  input  logic        func7,
  input  logic        func7_0,
  input  logic        zero,
  input  logic        res0,
  input  logic        mul_done,
  multicycle_control_unit_if.master bus,
  output logic        irwr,
  output logic        pcwr,
  output logic        regwr,
  output logic [3:0]  aluctr,
  output logic [1:0]  alubsrc,
  output logic [2:0]  extop,
  output logic        aluasrc,
  output logic        nxtbsrc,
  output logic [2:0]  memop,
  output logic [2:0]  state,
  output logic        trap
);

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             imem_req_r, dmem_req_r, dmem_we_r, pcwr_r, regwr_r, nxtbsrc_r, trap_r;
  logic [4:0]       op_r;
  logic [2:0]       func3_r;
  logic             func7_r;
  logic             legal_s, is_mem_s, is_store_s, is_branch_s, cnt_last_s, exec_done_s, taken_s;
  logic [3:0]       aluctr_s;
  logic [1:0]       alubsrc_s;
  logic [2:0]       extop_s, memop_s;

  assign legal_s     = (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_IMM) || (op == OP_REG) ||
                       (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH) ||
                       (op == OP_LOAD) || (op == OP_STORE);
  assign is_store_s  = (op_r == OP_STORE);
  assign is_mem_s    = (op_r == OP_LOAD) || is_store_s;
  assign is_branch_s = (op_r == OP_BRANCH);
  assign cnt_last_s  = (cnt_r == CNT_W'(TIMEOUT - 1));

`ifdef MULDIV_EN
  logic func7_0_r;
  assign exec_done_s = !((op_r == OP_REG) && func7_0_r) || mul_done;
`else
  logic unused_s;
  assign unused_s    = ^{func7_0, mul_done};
  assign exec_done_s = 1'b1;
`endif

  // Branch/jump outcome evaluated from the ALU flags during EXEC.
  always_comb begin
    taken_s = 1'b0;
    case (op_r)
      OP_JAL, OP_JALR: taken_s = 1'b1;
      OP_BRANCH: begin
        case (func3_r)
          3'b000:         taken_s = zero;
          3'b001:         taken_s = !zero;
          3'b100, 3'b110: taken_s = res0;
          3'b101, 3'b111: taken_s = zero | !res0;
          default:        taken_s = 1'b1;
        endcase
      end
      default: taken_s = 1'b0;
    endcase
  end

  // Datapath control decode from the fields latched in DECODE.
  always_comb begin
    aluctr_s  = 4'b1111;
    alubsrc_s = 2'd3;
    extop_s   = 3'd0;
    aluasrc_s_blk: begin end
    aluasrc   = 1'b0;
    case (op_r)
      OP_LUI:    begin aluctr_s = 4'b1111; alubsrc_s = 2'd1; extop_s = 3'd1; end
      OP_AUIPC:  begin aluctr_s = 4'b0000; alubsrc_s = 2'd1; extop_s = 3'd1; aluasrc = 1'b1; end
      OP_IMM:    begin aluctr_s = {func7_r & (func3_r == 3'b101), func3_r}; alubsrc_s = 2'd1; end
      OP_REG: begin
        alubsrc_s = 2'd0;
`ifdef MULDIV_EN
        if (func7_0_r) begin
          aluctr_s = {1'b1, func3_r};
        end else begin
          aluctr_s = {func7_r & ((func3_r == 3'b101) || (func3_r == 3'b000)), func3_r};
        end
`else
        aluctr_s = {func7_r & ((func3_r == 3'b101) || (func3_r == 3'b000)), func3_r};
`endif
      end
      OP_JAL:    begin aluctr_s = 4'b0000; alubsrc_s = 2'd2; extop_s = 3'd4; aluasrc = 1'b1; end
      OP_JALR:   begin aluctr_s = 4'b0000; alubsrc_s = 2'd2; extop_s = 3'd0; aluasrc = 1'b1; end
      OP_BRANCH: begin aluctr_s = func3_r[1] ? 4'b0011 : 4'b0010; alubsrc_s = 2'd0; extop_s = 3'd3; end
      OP_LOAD:   begin aluctr_s = 4'b0000; alubsrc_s = 2'd1; extop_s = 3'd0; end
      OP_STORE:  begin aluctr_s = 4'b0000; alubsrc_s = 2'd1; extop_s = 3'd2; end
      default:   begin aluctr_s = 4'b1111; alubsrc_s = 2'd3; extop_s = 3'd0; end
    endcase
  end

  // Access size/sign; anything outside LB/LH/LW/LBU/LHU is flagged as 3'b111.
  always_comb begin
    memop_s = 3'b111;
    case (func3_r)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: memop_s = func3_r;
      default:                                memop_s = 3'b111;
    endcase
  end

  // Sequencer: state, wait counter, latched fields and all registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      cnt_r      <= {CNT_W{1'b0}};
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      pcwr_r     <= 1'b0;
      regwr_r    <= 1'b0;
      nxtbsrc_r  <= 1'b0;
      trap_r     <= 1'b0;
      op_r       <= 5'b00000;
      func3_r    <= 3'b000;
      func7_r    <= 1'b0;
`ifdef MULDIV_EN
      func7_0_r  <= 1'b0;
`endif
    end else begin
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      pcwr_r     <= 1'b0;
      regwr_r    <= 1'b0;
      case (state_r)
        S_FETCH: begin
          // The request only goes out one cycle after reset release, so acks before it are ignored.
          if (imem_req_r && bus.imem_ack) begin
            state_r <= S_DECODE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (imem_req_r && cnt_last_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (imem_req_r) begin
            cnt_r      <= cnt_r + CNT_W'(1);
            imem_req_r <= 1'b1;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        S_DECODE: begin
          op_r    <= op;
          func3_r <= func3;
          func7_r <= func7;
`ifdef MULDIV_EN
          func7_0_r <= func7_0;
`endif
          if (legal_s) begin
            state_r <= S_EXEC;
          end else begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (exec_done_s) begin
            nxtbsrc_r <= taken_s;
            cnt_r     <= {CNT_W{1'b0}};
            if (is_mem_s) begin
              state_r    <= S_MEM;
              dmem_req_r <= 1'b1;
              dmem_we_r  <= is_store_s;
            end else begin
              state_r <= S_WB;
              pcwr_r  <= 1'b1;
              regwr_r <= !is_branch_s;
            end
          end else if (cnt_last_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            state_r <= S_WB;
            cnt_r   <= {CNT_W{1'b0}};
            pcwr_r  <= 1'b1;
            regwr_r <= !is_store_s;
          end else if (cnt_last_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
            dmem_req_r <= 1'b1;
            dmem_we_r  <= dmem_we_r;
          end
        end
        S_WB: begin
          state_r    <= S_FETCH;
          cnt_r      <= {CNT_W{1'b0}};
          imem_req_r <= 1'b1;
        end
        S_TRAP: begin
          state_r <= S_TRAP;
        end
        default: begin
          state_r <= S_TRAP;
          trap_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req = imem_req_r;
  assign bus.dmem_req = dmem_req_r;
  assign bus.dmem_we  = dmem_we_r;
  // IR must load in the very cycle the fetched word is on the bus.
  assign irwr    = imem_req_r & bus.imem_ack;
  assign pcwr    = pcwr_r;
  assign regwr   = regwr_r;
  assign aluctr  = aluctr_s;
  assign alubsrc = alubsrc_s;
  assign extop   = extop_s;
  assign nxtbsrc = nxtbsrc_r;
  assign memop   = memop_s;
  assign state   = state_r;
  assign trap    = trap_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: random instruction stream plus directed trap/reset cases.
// Expected WB-cycle responses are queued at issue time and checked by an independent monitor.
module tb_multicycle_control_unit;

  localparam logic [4:0] LUI = 5'b01101, AUIPC = 5'b00101, OPIMM = 5'b00100, OPREG = 5'b01100;
  localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BRANCH = 5'b11000;
  localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000;

  typedef struct {
    logic [3:0] aluctr;
    logic [1:0] alubsrc;
    logic [2:0] extop;
    logic       aluasrc;
    logic       nxtb;
    logic       regwr;
    logic       we;
    logic [2:0] memop;
    int         dreq;
    int         wboff;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] op;
  logic [2:0] func3;
  logic func7, func7_0, zero, res0, mul_done;
  logic irwr, pcwr, regwr, aluasrc, nxtbsrc, trap;
  logic [3:0] aluctr;
  logic [1:0] alubsrc;
  logic [2:0] extop, memop, state;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7), .func7_0(func7_0),
    .zero(zero), .res0(res0), .mul_done(mul_done), .bus(bus),
    .irwr(irwr), .pcwr(pcwr), .regwr(regwr), .aluctr(aluctr), .alubsrc(alubsrc), .extop(extop),
    .aluasrc(aluasrc), .nxtbsrc(nxtbsrc), .memop(memop), .state(state), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference behaviour of one instruction, straight from the instruction-class rules.
  function automatic exp_t model(input logic [4:0] o, input logic [2:0] f3, input logic f7, f70,
                                 input logic z, r0, input int ddly, xtra);
    exp_t e;
    e.aluctr = 4'd0; e.alubsrc = 2'd1; e.extop = 3'd0; e.aluasrc = 1'b0; e.nxtb = 1'b0;
    e.regwr  = !(o == BRANCH || o == STORE);
    e.we     = (o == STORE);
    e.memop  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 3'd7 : f3;
    e.dreq   = (o == LOAD || o == STORE) ? ddly + 1 : 0;
    e.wboff  = 3 + xtra + e.dreq;
    if (o == LUI) begin
      e.aluctr = 4'd15; e.extop = 3'd1;
    end else if (o == AUIPC) begin
      e.extop = 3'd1; e.aluasrc = 1'b1;
    end else if (o == OPIMM) begin
      e.aluctr = 4'(f3 + ((f3 == 3'd5 && f7) ? 8 : 0));
    end else if (o == OPREG) begin
      e.alubsrc = 2'd0;
      e.aluctr = 4'(f3 + ((f7 && (f3 == 3'd0 || f3 == 3'd5)) ? 8 : 0));
`ifdef MULDIV_EN
      if (f70) e.aluctr = 4'(8 + f3);
`endif
    end else if (o == JAL) begin
      e.alubsrc = 2'd2; e.extop = 3'd4; e.aluasrc = 1'b1; e.nxtb = 1'b1;
    end else if (o == JALR) begin
      e.alubsrc = 2'd2; e.aluasrc = 1'b1; e.nxtb = 1'b1;
    end else if (o == BRANCH) begin
      e.alubsrc = 2'd0; e.extop = 3'd3;
      e.aluctr = f3[1] ? 4'd3 : 4'd2;
      case (f3)
        3'd0:       e.nxtb = z;
        3'd1:       e.nxtb = !z;
        3'd4, 3'd6: e.nxtb = r0;
        3'd5, 3'd7: e.nxtb = z || !r0;
        default:    e.nxtb = 1'b1;
      endcase
    end else if (o == STORE) begin
      e.extop = 3'd2;
    end
    return e;
  endfunction

  task automatic wait_ireq();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("imem_req_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (bus.dmem_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("dmem_req_wait", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [4:0] o, input logic [2:0] f3, input logic f7, f70, z, r0,
                       input int idly, ddly, xtra, input bit push, input bit do_dmem);
    wait_ireq();
    repeat (idly) @(negedge clk);
    op = o; func3 = f3; func7 = f7; func7_0 = f70; zero = z; res0 = r0;
    if (push) sb.push_back(model(o, f3, f7, f70, z, r0, ddly, xtra));
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    if (do_dmem && (o == LOAD || o == STORE)) begin
      wait_dreq();
      repeat (ddly) @(negedge clk);
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("sb_drain", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples just after each falling edge, pops the scoreboard on every pcwr pulse.
  initial begin
    int cyc = 0, c_ir = 0, dreq_n = 0;
    logic we_seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        dreq_n = 0; we_seen = 1'b0;
      end else begin
        if (irwr === 1'b1) begin c_ir = cyc; dreq_n = 0; we_seen = 1'b0; end
        if (bus.dmem_req === 1'b1) begin dreq_n++; we_seen = bus.dmem_we; end
        if (pcwr === 1'b1) begin
          if (sb.size() == 0) begin
            chk("pcwr_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("aluctr", aluctr, e.aluctr);
            chk("alubsrc", alubsrc, e.alubsrc);
            chk("extop", extop, e.extop);
            chk("aluasrc", aluasrc, e.aluasrc);
            chk("nxtbsrc", nxtbsrc, e.nxtb);
            chk("regwr", regwr, e.regwr);
            chk("memop", memop, e.memop);
            chk("dmem_we", we_seen, e.we);
            chk("dmem_req_cycles", dreq_n, e.dreq);
            chk("wb_latency", cyc - c_ir, e.wboff);
            chk("wb_state", state, 32'd4);
            chk("no_trap", trap, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    logic [4:0] ops [9];
    int n;
    ops = '{LUI, AUIPC, OPIMM, OPREG, JAL, JALR, BRANCH, LOAD, STORE};
    rst_n = 1'b0; op = 5'd0; func3 = 3'd0; func7 = 1'b0; func7_0 = 1'b0;
    zero = 1'b0; res0 = 1'b0; mul_done = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    #3;
    chk("rst_state", state, 32'd0);
    chk("rst_imem_req", bus.imem_req, 32'd0);
    chk("rst_dmem_req", bus.dmem_req, 32'd0);
    chk("rst_strobes", {irwr, pcwr, regwr}, 32'd0);
    chk("rst_trap_nxtb", {trap, nxtbsrc}, 32'd0);
    chk("rst_decode", {aluctr, alubsrc, extop, aluasrc, memop}, {4'd0, 2'd1, 3'd0, 1'b0, 3'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("imem_req_after_release", bus.imem_req, 32'd1);

    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(8, 0)], 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            $urandom_range(3, 0), $urandom_range(3, 0), 0, 1'b1, 1'b1);
    end

    issue(OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);   // addi
    issue(BRANCH, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b1);  // beq taken
    issue(BRANCH, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b1);  // bge not taken
    issue(LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1'b1, 1'b1);    // lw, late ack
    issue(STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);   // sw
    issue(OPIMM, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 15, 0, 0, 1'b1, 1'b1);  // ack on the last allowed cycle
    issue(LOAD, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 15, 0, 1'b1, 1'b1);   // dmem ack on the last allowed cycle
    drain();

`ifdef MULDIV_EN
    mul_done = 1'b0;
    issue(OPREG, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    mul_done = 1'b1;
    drain();
`else
    mul_done = 1'b0;
    issue(OPREG, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
    drain();
    mul_done = 1'b1;
`endif

    do_reset();
    wait_ireq();
    n = 0;
    while (bus.imem_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
    chk("timeout_cycles", n, 32'd16);
    chk("timeout_state", state, 32'd5);
    chk("timeout_trap", trap, 32'd1);
    chk("timeout_imem_req", bus.imem_req, 32'd0);
    repeat (5) @(negedge clk);
    chk("trap_sticky", {trap, state}, {1'b1, 3'd5});

    do_reset();
    chk("trap_cleared", trap, 32'd0);
    issue(5'b11111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("illegal_state", state, 32'd5);
    chk("illegal_trap", trap, 32'd1);

    do_reset();
    issue(LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    wait_dreq();
    chk("mem_state", state, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dmem_req", bus.dmem_req, 32'd0);
    chk("async_rst_state", state, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
